// File: rtl/reg_writeback.sv
// reg_writeback: two-entry write-back queue between the load/ALU request
// ports and a single register-file write port.
//   - Load requests have fixed priority over ALU requests; one accept per edge.
//   - Requests targeting index 6 or 7 are accepted but discarded (rwbDROP pulse).
//   - The queue head is presented combinationally and pops when written.
// Optional feature macro: RWB_FORWARD_EN (youngest-match data forwarding).
module reg_writeback (
  input  logic       rwbCLK,
  input  logic       rwbRST,
  input  logic       rwbLdVALID,
  input  logic [2:0] rwbLdADDR,
  input  logic [4:0] rwbLdDATA,
  output logic       rwbLdREADY,
  input  logic       rwbAluVALID,
  input  logic [2:0] rwbAluADDR,
  input  logic [4:0] rwbAluDATA,
  output logic       rwbAluREADY,
  input  logic       rwbSTALL,
  output logic [2:0] rwbWr,
  output logic       rwbEN,
  output logic [4:0] rwbWRD,
  input  logic [2:0] rwbChkA,
  output logic       rwbPendA,
  output logic       rwbDROP,
  output logic [1:0] rwbCOUNT,
  output logic       rwbFwdHIT,
  output logic [4:0] rwbFwdDATA
);

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 5;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = 2;

  localparam logic [IDX_W-1:0] DROP_MIN_IDX = IDX_W'(6);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(DEPTH);

  // Queue storage and bookkeeping
  logic [IDX_W-1:0]  r_idx  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_drop;

  // Request selection and queue control
  logic              w_full;
  logic              w_empty;
  logic              w_ld_acc;
  logic              w_alu_acc;
  logic              w_acc;
  logic [IDX_W-1:0]  w_acc_idx;
  logic [DATA_W-1:0] w_acc_data;
  logic              w_push;
  logic              w_pop;
  logic              w_tail_ptr;
  logic              w_hit_head;
  logic              w_hit_tail;

  assign w_full     = (r_count == CNT_FULL);
  assign w_empty    = (r_count == CNT_W'(0));
  assign w_tail_ptr = ~r_rd_ptr;

  // Readiness depends on fullness only, never on a same-cycle pop
  assign rwbLdREADY  = !rwbRST && !w_full;
  assign rwbAluREADY = !rwbRST && !w_full && !rwbLdVALID;

  assign w_ld_acc  = rwbLdVALID  && rwbLdREADY;
  assign w_alu_acc = rwbAluVALID && rwbAluREADY;
  assign w_acc     = w_ld_acc || w_alu_acc;

  // Mux the accepted request; load wins whenever it is accepted
  always_comb begin
    w_acc_idx  = '0;
    w_acc_data = '0;
    if (w_ld_acc) begin
      w_acc_idx  = rwbLdADDR;
      w_acc_data = rwbLdDATA;
    end else if (w_alu_acc) begin
      w_acc_idx  = rwbAluADDR;
      w_acc_data = rwbAluDATA;
    end
  end

  assign w_push = w_acc && (w_acc_idx < DROP_MIN_IDX);
  assign w_pop  = rwbEN;

  // Register-file write port: head of queue, zero when empty or in reset
  assign rwbEN    = !rwbRST && !w_empty && !rwbSTALL;
  assign rwbWr    = (rwbRST || w_empty) ? '0 : r_idx[r_rd_ptr];
  assign rwbWRD   = (rwbRST || w_empty) ? '0 : r_data[r_rd_ptr];
  assign rwbCOUNT = r_count;
  assign rwbDROP  = r_drop;

  // Pending-write check against valid entries only (head, then tail)
  assign w_hit_head = !w_empty && (r_idx[r_rd_ptr] == rwbChkA);
  assign w_hit_tail = w_full   && (r_idx[w_tail_ptr] == rwbChkA);
  assign rwbPendA   = !rwbRST && (w_hit_head || w_hit_tail);

`ifdef RWB_FORWARD_EN
  // Forward the youngest matching entry; the tail is younger than the head
  always_comb begin
    rwbFwdHIT  = rwbPendA;
    rwbFwdDATA = '0;
    if (!rwbRST) begin
      if (w_hit_tail) begin
        rwbFwdDATA = r_data[w_tail_ptr];
      end else if (w_hit_head) begin
        rwbFwdDATA = r_data[r_rd_ptr];
      end
    end
  end
`else
  assign rwbFwdHIT  = 1'b0;
  assign rwbFwdDATA = '0;
`endif

  // Queue state update: push at tail, pop at head, pointers wrap modulo 2
  always_ff @(posedge rwbCLK or posedge rwbRST) begin
    if (rwbRST) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
      r_drop   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_idx[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_drop <= w_acc && !w_push;
      if (w_push) begin
        r_idx[r_wr_ptr]  <= w_acc_idx;
        r_data[r_wr_ptr] <= w_acc_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= CNT_W'(r_count + CNT_W'(1));
        2'b01:   r_count <= CNT_W'(r_count - CNT_W'(1));
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named in the codebase's module-prefixed style.
REQ-002 rwbCLK  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rwbRST  in  1  asynchronous, active-high reset.
REQ-004 rwbLdVALID/rwbLdADDR/rwbLdDATA  in  1/3/5  load-unit write request: valid, register index, data.
REQ-005 rwbLdREADY  out  1  load request accepted on this edge when high together with rwbLdVALID.
REQ-006 rwbAluVALID/rwbAluADDR/rwbAluDATA  in  1/3/5  ALU write request: valid, register index, data.
REQ-007 rwbAluREADY  out  1  ALU request accepted on this edge when high together with rwbAluVALID.
REQ-008 rwbSTALL  in  1  register-file write port unavailable; no drain this cycle.
REQ-009 rwbWr/rwbEN/rwbWRD  out  3/1/5  register-file write index, write enable, write data.
REQ-010 rwbChkA  in  3  register index to check for pending writes.
REQ-011 rwbPendA  out  1  high when any queued entry targets rwbChkA.
REQ-012 rwbDROP  out  1  one-cycle pulse: the previous cycle's accepted request targeted index 6 or 7.
REQ-013 rwbCOUNT  out  2  number of queued entries, 0..2.
REQ-014 rwbFwdHIT/rwbFwdDATA  out  1/5  forwarding outputs (see Configuration).

Function
REQ-015 The block SHALL contain a 2-entry FIFO of {index[2:0], data[4:0]}; full = (COUNT==2).
REQ-016 rwbLdREADY SHALL equal !full; rwbAluREADY SHALL equal !full & !rwbLdVALID. Load has fixed priority, and at most one request is accepted per edge.
REQ-017 An accepted request with index 0..5 SHALL be pushed at the accepting edge.
REQ-018 An accepted request with index 6 or 7 SHALL NOT be pushed; rwbDROP SHALL be 1 for the following cycle.
REQ-019 rwbWr and rwbWRD SHALL present the FIFO head combinationally, or 0 when the FIFO is empty.
REQ-020 rwbEN SHALL equal (COUNT!=0) & !rwbSTALL.
REQ-021 When rwbEN is high, the head SHALL pop at the same edge at which the register file samples it.
REQ-022 Latency SHALL be one edge from acceptance to queued and one further edge to the register-file write, with no stall.
REQ-023 Push and pop in the same edge SHALL leave COUNT unchanged, and entry order SHALL be preserved.
REQ-024 Readiness SHALL depend on full only, not on a same-cycle pop; when COUNT is 2, no request is accepted even if a pop occurs.
REQ-025 Pointers SHALL wrap modulo 2.
REQ-026 Requests SHALL not overflow or underflow the FIFO. Pops SHALL be impossible when empty.
REQ-027 rwbPendA SHALL compare rwbChkA against valid entries only; the in-flight input request is excluded.

Reset
REQ-028 While rwbRST is high, COUNT, pointers and rwbDROP SHALL be 0.
REQ-029 While rwbRST is high, rwbEN, rwbWr, rwbWRD, rwbPendA, rwbFwdHIT and rwbFwdDATA SHALL be 0.
REQ-030 While rwbRST is high, both READY outputs SHALL be forced to 0.
REQ-031 Reset asserted mid-operation SHALL discard queued entries immediately without issuing a write.
REQ-032 Operation SHALL resume on the first rising edge after deassertion.

Configuration
REQ-033 With RWB_FORWARD_EN defined, rwbFwdHIT SHALL equal rwbPendA, and rwbFwdDATA SHALL give the data of the youngest matching entry (0 if none).
REQ-034 Without RWB_FORWARD_EN, rwbFwdHIT and rwbFwdDATA SHALL be tied to 0, and no forwarding logic SHALL be synthesized.

Verification
REQ-035 Ld {idx 2, data 5'h13}, no stall -> edge 1 rwbCOUNT=1; cycle 2 rwbEN=1, rwbWr=2, rwbWRD=13h; edge 2 rwbCOUNT=0.
REQ-036 LdVALID and AluVALID both high, COUNT 0 -> LdREADY=1, AluREADY=0; only the load entry is queued.
REQ-037 STALL=1; push {1,04h} then {3,1Fh} -> COUNT=2, both READY=0; STALL drops -> writes idx 1 then idx 3 on consecutive edges.
REQ-038 Alu {idx 7, data 0Ah} -> accepted, COUNT stays 0, rwbDROP=1 for one cycle, rwbEN never high.
REQ-039 STALL=1; queue {4,01h},{4,02h}; ChkA=4 -> PendA=1; with RWB_FORWARD_EN, FwdDATA=02h; ChkA=5 -> PendA=0.
REQ-040 rwbRST pulsed while COUNT=2 -> COUNT=0, rwbEN=0 immediately, and no register write occurs.
